// File: rtl/mc_host.sv
// Matrix-engine host: accepts a command, streams a generated payload burst to the
// engine, then collects and summarises the engine's result words.
module mc_host #(
    parameter int unsigned TIMEOUT = 4095
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_action,
    input  logic [1:0]  cmd_size,
    input  logic [31:0] cmd_seed,
    output logic        mc_in_valid,
    output logic [31:0] mc_in_data,
    output logic [1:0]  mc_size,
    output logic [2:0]  mc_action,
    input  logic        mc_out_valid,
    input  logic [31:0] mc_out_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [10:0] rsp_count,
    output logic [31:0] rsp_sum,
    output logic [31:0] rsp_first,
    output logic        rsp_err,
    output logic        rsp_timeout
);
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT, S_RECV, S_DONE} state_t;

    state_t        r_state;
    logic [1:0]    r_len;
    logic          r_len_valid;
    logic [31:0]   r_seed;
    logic [10:0]   r_nbeats;
    logic [10:0]   r_exp;
    logic [10:0]   r_beat;
    logic [TW-1:0] r_wait;

    logic          w_is_setup;
    logic          w_multi;
    logic          w_reject;
    logic [1:0]    w_len_code;
    logic [10:0]   w_square;
    logic [10:0]   w_nbeats;
    logic [10:0]   w_exp;

    // Setup takes its size from the command itself, everything else from stored LEN.
    always_comb begin
        w_is_setup = (cmd_action == 3'd4);
        w_multi    = cmd_action[2];
        w_reject   = (cmd_action == 3'd7) || (!w_is_setup && !r_len_valid);
        w_len_code = w_is_setup ? cmd_size : r_len;
        w_square   = 11'd16 << {w_len_code, 1'b0};
        w_nbeats   = w_multi ? w_square : 11'd1;
        w_exp      = (cmd_action == 3'd0) ? 11'd1 : w_square;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_len       <= '0;
            r_len_valid <= 1'b0;
            r_seed      <= '0;
            r_nbeats    <= '0;
            r_exp       <= '0;
            r_beat      <= '0;
            r_wait      <= '0;
            cmd_ready   <= 1'b0;
            mc_in_valid <= 1'b0;
            mc_in_data  <= '0;
            mc_size     <= '0;
            mc_action   <= '0;
            rsp_valid   <= 1'b0;
            rsp_count   <= '0;
            rsp_sum     <= '0;
            rsp_first   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_ready && cmd_valid) begin
                        cmd_ready <= 1'b0;
                        r_seed    <= cmd_seed;
                        if (w_reject) begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            r_state   <= S_DONE;
                        end else begin
                            if (w_is_setup) begin
                                r_len       <= cmd_size;
                                r_len_valid <= 1'b1;
                            end
                            // Beat 0 is issued here so it appears one cycle after acceptance.
                            r_nbeats    <= w_nbeats;
                            r_exp       <= w_exp;
                            r_beat      <= 11'd1;
                            mc_in_valid <= 1'b1;
                            mc_in_data  <= w_multi ? cmd_seed : '0;
                            mc_action   <= cmd_action;
                            mc_size     <= w_len_code;
                            r_state     <= S_SEND;
                        end
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                S_SEND: begin
                    mc_action <= '0;
                    mc_size   <= '0;
                    if (r_beat == r_nbeats) begin
                        mc_in_valid <= 1'b0;
                        mc_in_data  <= '0;
                        r_wait      <= '0;
                        r_state     <= S_WAIT;
                    end else begin
                        mc_in_data <= r_seed + 32'(r_beat);
                        r_beat     <= r_beat + 11'd1;
                    end
                end
                S_WAIT: begin
                    if (mc_out_valid) begin
                        rsp_count <= 11'd1;
                        rsp_sum   <= mc_out_data;
                        rsp_first <= mc_out_data;
                        if (r_exp == 11'd1) begin
                            rsp_valid <= 1'b1;
                            r_state   <= S_DONE;
                        end else begin
                            r_state <= S_RECV;
                        end
                    end else if (r_wait == TW'(TIMEOUT - 1)) begin
                        rsp_timeout <= 1'b1;
                        rsp_valid   <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_wait <= r_wait + TW'(1);
                    end
                end
                S_RECV: begin
                    if (mc_out_valid) begin
                        rsp_count <= rsp_count + 11'd1;
                        rsp_sum   <= rsp_sum + mc_out_data;
                        if (rsp_count + 11'd1 == r_exp) begin
                            rsp_valid <= 1'b1;
                            r_state   <= S_DONE;
                        end
                    end else begin
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        r_state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (rsp_ready) begin
                        rsp_valid   <= 1'b0;
                        rsp_count   <= '0;
                        rsp_sum     <= '0;
                        rsp_first   <= '0;
                        rsp_err     <= 1'b0;
                        rsp_timeout <= 1'b0;
                        cmd_ready   <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mc_host.sv
// Scoreboard bench for mc_host: expected beats and summaries are queued at command
// time and compared as the host emits bursts and summaries.
module tb_mc_host;
    localparam int unsigned TO = 100;

    typedef struct packed {
        logic [31:0] data;
        logic [2:0]  act;
        logic [1:0]  sz;
    } beat_t;

    typedef struct packed {
        logic [10:0] cnt;
        logic [31:0] sum;
        logic [31:0] first;
        logic        err;
        logic        to;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_action;
    logic [1:0]  cmd_size;
    logic [31:0] cmd_seed;
    logic        mc_in_valid;
    logic [31:0] mc_in_data;
    logic [1:0]  mc_size;
    logic [2:0]  mc_action;
    logic        mc_out_valid;
    logic [31:0] mc_out_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [10:0] rsp_count;
    logic [31:0] rsp_sum;
    logic [31:0] rsp_first;
    logic        rsp_err;
    logic        rsp_timeout;

    int n_checks = 0;
    int n_fail = 0;
    int beats_seen = 0;
    int bursts_seen = 0;
    int low_run = 0;
    int gap_viol = 0;
    int stray = 0;
    logic prev_valid = 1'b0;

    beat_t exp_beat_q[$];
    rsp_t  exp_rsp_q[$];

    logic [1:0] len_m = 2'd0;
    logic       len_valid_m = 1'b0;

    mc_host #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_action(cmd_action),
        .cmd_size(cmd_size), .cmd_seed(cmd_seed),
        .mc_in_valid(mc_in_valid), .mc_in_data(mc_in_data), .mc_size(mc_size),
        .mc_action(mc_action), .mc_out_valid(mc_out_valid), .mc_out_data(mc_out_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_count(rsp_count),
        .rsp_sum(rsp_sum), .rsp_first(rsp_first), .rsp_err(rsp_err),
        .rsp_timeout(rsp_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Input-side monitor: every beat is matched against the queued expectation.
    always @(negedge clk) begin
        beat_t eb;
        if (mc_in_valid === 1'b1) begin
            if (!prev_valid) begin
                bursts_seen++;
                if (bursts_seen > 1 && low_run < 2) gap_viol++;
            end
            beats_seen++;
            if (exp_beat_q.size() == 0) begin
                check("beat_unexpected", 64'd1, 64'd0);
            end else begin
                eb = exp_beat_q.pop_front();
                check("beat_data", 64'(mc_in_data), 64'(eb.data));
                check("beat_action", 64'(mc_action), 64'(eb.act));
                check("beat_size", 64'(mc_size), 64'(eb.sz));
            end
            prev_valid = 1'b1;
            low_run = 0;
        end else begin
            if (mc_action !== 3'd0 || mc_size !== 2'd0) stray++;
            prev_valid = 1'b0;
            low_run++;
        end
    end

    task automatic push_beats(input logic [2:0] act, input logic [31:0] seed, input int unsigned n);
        beat_t b;
        for (int unsigned k = 0; k < n; k++) begin
            b.data = (n > 1) ? seed + 32'(k) : 32'd0;
            b.act  = (k == 0) ? act : 3'd0;
            b.sz   = (k == 0) ? len_m : 2'd0;
            exp_beat_q.push_back(b);
        end
    endtask

    task automatic drive_cmd(input logic [2:0] act, input logic [1:0] sz, input logic [31:0] seed);
        int t = 0;
        @(negedge clk);
        while (!cmd_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!cmd_ready) check("cmd_ready_wait", 64'd0, 64'd1);
        cmd_valid  = 1'b1;
        cmd_action = act;
        cmd_size   = sz;
        cmd_seed   = seed;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    // One command end to end: model, drive, respond with nw words, check summary.
    task automatic run(input logic [2:0] act, input logic [1:0] sz, input logic [31:0] seed,
                       input int unsigned nw, input logic [31:0] base, input int unsigned dly);
        logic rej;
        int unsigned side, n, e, lat, t;
        int b0, bb0;
        rsp_t er, gr;
        rej = (act == 3'd7) || (act != 3'd4 && !len_valid_m);
        if (act == 3'd4) begin
            len_m = sz;
            len_valid_m = 1'b1;
        end
        side = 4 << len_m;
        n = rej ? 0 : ((act >= 3'd4) ? side * side : 1);
        e = (act == 3'd0) ? 1 : side * side;
        push_beats(act, seed, n);
        er = '0;
        if (rej) begin
            er.err = 1'b1;
        end else if (nw == 0) begin
            er.to = 1'b1;
        end else begin
            er.cnt = 11'((nw < e) ? nw : e);
            er.first = base;
            for (int unsigned i = 0; i < er.cnt; i++) er.sum = er.sum + base + 32'(i);
            er.err = (nw < e);
        end
        exp_rsp_q.push_back(er);
        b0 = beats_seen;
        bb0 = bursts_seen;

        drive_cmd(act, sz, seed);
        check("first_beat_latency", 64'(mc_in_valid), 64'(!rej));
        check("cmd_ready_low", 64'(cmd_ready), 64'd0);

        if (!rej) begin
            t = 0;
            @(negedge clk);
            while (mc_in_valid && t < 3000) begin
                @(negedge clk);
                t++;
            end
            if (nw == 0) begin
                lat = 0;
                while (!rsp_valid && lat < TO + 100) begin
                    lat++;
                    @(negedge clk);
                end
                check("timeout_latency", 64'(lat), 64'(TO));
            end else begin
                repeat (dly) @(negedge clk);
                for (int unsigned i = 0; i < nw; i++) begin
                    mc_out_valid = 1'b1;
                    mc_out_data  = base + 32'(i);
                    @(negedge clk);
                end
                mc_out_valid = 1'b0;
                mc_out_data  = '0;
            end
        end

        t = 0;
        while (!rsp_valid && t < TO + 100) begin
            @(negedge clk);
            t++;
        end
        check("rsp_valid_seen", 64'(rsp_valid), 64'd1);
        gr = exp_rsp_q.pop_front();
        check("rsp_count", 64'(rsp_count), 64'(gr.cnt));
        check("rsp_sum", 64'(rsp_sum), 64'(gr.sum));
        check("rsp_first", 64'(rsp_first), 64'(gr.first));
        check("rsp_err", 64'(rsp_err), 64'(gr.err));
        check("rsp_timeout", 64'(rsp_timeout), 64'(gr.to));
        repeat (2) begin
            @(negedge clk);
            check("rsp_hold", {20'd0, rsp_valid, rsp_count, rsp_sum}, {20'd0, 1'b1, gr.cnt, gr.sum});
        end
        check("beat_count", 64'(beats_seen - b0), 64'(n));
        check("burst_count", 64'(bursts_seen - bb0), 64'((n > 0) ? 1 : 0));
        check("beat_queue_empty", 64'(exp_beat_q.size()), 64'd0);

        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check("rsp_valid_drop", 64'(rsp_valid), 64'd0);
        check("cmd_ready_back", 64'(cmd_ready), 64'd1);
        check("acc_cleared", 64'(rsp_count), 64'd0);
    endtask

    initial begin
        int k, t, b0;
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_action = '0;
        cmd_size = '0;
        cmd_seed = '0;
        mc_out_valid = 1'b0;
        mc_out_data = '0;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        check("rst_mc_in_valid", 64'(mc_in_valid), 64'd0);
        check("rst_rsp", {rsp_valid, rsp_err, rsp_timeout, rsp_count, rsp_sum}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("cmd_ready_after_rst", 64'(cmd_ready), 64'd1);

        run(3'd0, 2'd0, 32'h0,        1,    32'h5,        0);  // trace before any setup
        run(3'd4, 2'd0, 32'h10,       16,   32'd1,        0);  // setup 4x4
        run(3'd7, 2'd0, 32'h1234,     0,    32'h0,        0);  // illegal action
        run(3'd4, 2'd1, 32'hFFFF_FFF0, 64,  32'd100,      1);  // setup 8x8, seed wraps
        run(3'd1, 2'd3, 32'hABCD,     64,   32'd7,        2);  // mirror keeps LEN 8
        run(3'd0, 2'd2, 32'h99,       1,    32'hDEAD_BEEF, 4); // trace, single word
        run(3'd4, 2'd0, 32'h40,       16,   32'd2,        0);
        run(3'd2, 2'd0, 32'h0,        0,    32'h0,        0);  // transpose, silent -> timeout
        run(3'd5, 2'd0, 32'h300,      5,    32'd10,       1);  // addition truncated
        run(3'd6, 2'd0, 32'h8000_0000, 16,  32'hFFFF_FFF8, 3); // multiplication

        // Reset while beat 7 of a 64-beat setup burst is on the bus.
        len_m = 2'd1;
        len_valid_m = 1'b1;
        push_beats(3'd4, 32'h200, 64);
        b0 = beats_seen;
        drive_cmd(3'd4, 2'd1, 32'h200);
        k = 0;
        t = 0;
        while (k < 8 && t < 200) begin
            @(negedge clk);
            t++;
            if (mc_in_valid) begin
                if (k == 7) rst = 1'b1;
                k++;
            end
        end
        @(posedge clk);
        #1;
        check("rst_mid_send_valid", 64'(mc_in_valid), 64'd0);
        check("rst_mid_send_ready", 64'(cmd_ready), 64'd0);
        check("rst_mid_send_rsp", 64'(rsp_valid), 64'd0);
        exp_beat_q.delete();
        len_valid_m = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_release_ready", 64'(cmd_ready), 64'd1);
        check("rst_release_rsp", 64'(rsp_valid), 64'd0);
        check("beats_before_rst", 64'(beats_seen - b0), 64'd8);

        run(3'd0, 2'd0, 32'h0,        1,    32'h1,        0);  // LEN-valid cleared
        run(3'd4, 2'd3, 32'h0,        1024, 32'd1,        0);  // largest burst, E=1024

        check("gap_violations", 64'(gap_viol), 64'd0);
        check("stray_header", 64'(stray), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end
endmodule
